// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// state encoding and the legal operand-width range.
package serial_addsub_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_addsub_ctrl_fa_cell.sv
// Combinational 1-bit full adder, time-shared by the serial sequencer.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one shared full-adder cell,
// LSB first, valid/ready on both operand and result sides.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// BUSY  | one bit per clock through fa_cell, counter tracks the bit
// DONE  | result/cout/ovf presented with out_valid=1 until out_ready
module serial_addsub_ctrl
    import serial_addsub_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_addsub_ctrl: WIDTH out of range");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (state == BUSY) && (cnt == CNT_LAST);

    fa_cell u_fa_cell (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is a + ~b + 1: invert b on load and seed the carry with sub.
    // The presented outputs load only on the final bit so they stay put
    // while the next operation is shifting through res_sr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sr   <= op_a;
            b_sr   <= op_b ^ {WIDTH{sub}};
            res_sr <= '0;
            cnt    <= '0;
            carry  <= sub;
        end else if (state == BUSY) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa_s, res_sr[WIDTH-1:1]};
            carry  <= fa_co;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                result <= {fa_s, res_sr[WIDTH-1:1]};
                cout   <= fa_co;
                ovf    <= carry ^ fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench: WIDTH=8 directed/random operations plus an
// exhaustive WIDTH=4 sweep, both against an arithmetic reference model.
module tb_serial_addsub_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b0;
    logic [7:0] op_a8 = '0, op_b8 = '0;
    logic       in_ready8, out_valid8, cout8, ovf8;
    logic [7:0] result8;

    logic       in_valid4 = 1'b0, sub4 = 1'b0, out_ready4 = 1'b0;
    logic [3:0] op_a4 = '0, op_b4 = '0;
    logic       in_ready4, out_valid4, cout4, ovf4;
    logic [3:0] result4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_addsub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .sub       (sub8),
        .op_a      (op_a8),
        .op_b      (op_b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .result    (result8),
        .cout      (cout8),
        .ovf       (ovf8)
    );

    serial_addsub_ctrl #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .sub       (sub4),
        .op_a      (op_a4),
        .op_b      (op_b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .result    (result4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int w, input bit s, input int a, input int b,
                                  output int r, output bit c, output bit v);
        int m, h, sa, sb, t, st;
        m  = 1 << w;
        h  = m / 2;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        t  = s ? a - b : a + b;
        r  = ((t % m) + m) % m;
        c  = s ? (a >= b) : (a + b >= m);
        st = s ? sa - sb : sa + sb;
        v  = (st >= h) || (st < -h);
    endfunction

    task automatic drive(input bit u4, input bit v, input bit s,
                         input logic [31:0] a, input logic [31:0] b, input bit ordy);
        if (u4) begin
            in_valid4 = v; sub4 = s; op_a4 = a[3:0]; op_b4 = b[3:0]; out_ready4 = ordy;
        end else begin
            in_valid8 = v; sub8 = s; op_a8 = a[7:0]; op_b8 = b[7:0]; out_ready8 = ordy;
        end
    endtask

    task automatic sample(input bit u4, output bit ov, output bit ir,
                          output logic [31:0] res, output bit c, output bit v);
        if (u4) begin
            ov = out_valid4; ir = in_ready4; res = {28'd0, result4}; c = cout4; v = ovf4;
        end else begin
            ov = out_valid8; ir = in_ready8; res = {24'd0, result8}; c = cout8; v = ovf8;
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic run_op(input bit u4, input bit s, input int a, input int b,
                          input int stall, input string tag);
        int  w, er, lat, rdy_bad, hold_bad;
        bit  ec, ev, ov, ir, c, v;
        logic [31:0] res;
        w = u4 ? 4 : 8;
        model(w, s, a, b, er, ec, ev);
        sample(u4, ov, ir, res, c, v);
        check({tag, " idle_in_ready"}, 32'(ir), 32'd1);
        drive(u4, 1'b1, s, a, b, 1'b0);
        @(posedge clk); #1;
        drive(u4, 1'b0, s, a, b, 1'b0);
        lat = 0;
        rdy_bad = 0;
        sample(u4, ov, ir, res, c, v);
        while (!ov && lat < 40) begin
            if (ir) rdy_bad++;
            @(posedge clk); #1;
            lat++;
            sample(u4, ov, ir, res, c, v);
        end
        check({tag, " latency"}, 32'(lat), 32'(w));
        check({tag, " result"}, res, 32'(er));
        check({tag, " cout"}, 32'(c), 32'(ec));
        check({tag, " ovf"}, 32'(v), 32'(ev));
        hold_bad = rdy_bad;
        for (int i = 0; i < stall; i++) begin
            drive(u4, 1'b1, ~s, $urandom, $urandom, 1'b0);
            @(posedge clk); #1;
            sample(u4, ov, ir, res, c, v);
            if (!ov || ir || res != 32'(er) || c != ec || v != ev) hold_bad++;
        end
        check({tag, " busy_done_hold"}, 32'(hold_bad), 32'd0);
        drive(u4, 1'b0, 1'b0, 0, 0, 1'b1);
        @(posedge clk); #1;
        drive(u4, 1'b0, 1'b0, 0, 0, 1'b0);
        sample(u4, ov, ir, res, c, v);
        check({tag, " release_out_valid"}, 32'(ov), 32'd0);
        check({tag, " release_in_ready"}, 32'(ir), 32'd1);
    endtask

    initial begin
        bit ov, ir, c, v;
        logic [31:0] res;

        #12;
        for (int u = 0; u < 2; u++) begin
            sample(u[0], ov, ir, res, c, v);
            check("reset out_valid", 32'(ov), 32'd0);
            check("reset in_ready", 32'(ir), 32'd1);
            check("reset result", res, 32'd0);
            check("reset cout_ovf", 32'({c, v}), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(1'b0, 1'b0, 'h35, 'h4A, 0, "add_35_4a");
        run_op(1'b0, 1'b0, 'h7F, 'h01, 1, "add_7f_01");
        run_op(1'b0, 1'b0, 'hFF, 'h01, 0, "add_ff_01");
        run_op(1'b0, 1'b1, 'h10, 'h20, 2, "sub_10_20");
        run_op(1'b0, 1'b1, 'h80, 'h01, 0, "sub_80_01");
        run_op(1'b0, 1'b0, 'hA5, 'h3C, 5, "backpressure");
        run_op(1'b0, 1'b1, 'h00, 'h00, 0, "after_backpressure");

        // Abort in the middle of bit 3, then confirm clean recovery.
        drive(1'b0, 1'b1, 1'b0, 'hC3, 'h5A, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sample(1'b0, ov, ir, res, c, v);
        check("midop_reset out_valid", 32'(ov), 32'd0);
        check("midop_reset in_ready", 32'(ir), 32'd1);
        check("midop_reset result", res, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 1'b0, 'h01, 'h01, 0, "post_reset_01_01");

        for (int i = 0; i < 30; i++)
            run_op(1'b0, 1'($urandom), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), "rand8");

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run_op(1'b1, s[0], a, b, int'($urandom_range(0, 2)),
                           $sformatf("w4 s%0d a%0h b%0h", s, a, b));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
